scalar_rf_write_controller: RTL and testbench
=============================================

// Module: scalar_rf_write_controller
// PURPOSE
// - Owns the write port of scalar_register_file and post-processes its read data.
// - Zeroes all STRANDS*32 registers after reset, since the register file has no reset.
// - Arbitrates the pipeline writeback against the memory fill source. Starvation is bounded.
// - Forwards data on a same-cycle read/write collision, so the pipeline never sees the file's X.
// PARAMETERS
// NUM_STRANDS     `STRANDS_PER_CORE  strands per core; register count = NUM_STRANDS*32
// REG_IDX_WIDTH   `REG_IDX_WIDTH     register index width; must equal $clog2(NUM_STRANDS*32)
// STARVE_LIMIT    8                  consecutive fill-blocked cycles before a pipeline stall request
// PORTS
// clk                     in   1    clock
// reset                   in   1    synchronous, active-high
// wb_enable_scalar_writeback in 1   pipeline writeback valid; cannot be back-pressured
// wb_writeback_reg        in   REG_IDX_WIDTH  pipeline writeback index
// wb_writeback_value      in   32   pipeline writeback data
// fill_valid              in   1    fill source write request
// fill_reg                in   REG_IDX_WIDTH  fill index
// fill_value              in   32   fill data
// fill_ready              out  1    fill accepted this cycle (valid && ready)
// sc_stall_request        out  1    asks the pipeline for a writeback bubble
// sc_init_busy            out  1    clear sequence in progress; pipeline must not issue
// rf_write_enable         out  1    to register file write enable
// rf_write_reg            out  REG_IDX_WIDTH  to register file write index
// rf_write_value          out  32   to register file write data
// ds_scalar_sel1/2        in   REG_IDX_WIDTH  read indices (also routed to the register file)
// rf_scalar_value1/2      in   32   raw register file read data (1-cycle latency)
// sc_scalar_value1/2      out  32   corrected read data to the pipeline (same cycle as rf_*)
// BEHAVIOUR
// - Reset values:
//   - state=CLEAR, clear_idx=0, sc_init_busy=1, rf_write_enable=0, fill_ready=0.
//   - sc_stall_request=0, starve_cnt=0, both forward flags=0.
// - The write port is a registered mux. A request accepted in cycle N drives rf_write_* in cycle N+1.
// - CLEAR state:
//   - Each cycle drives rf_write_enable=1, rf_write_reg=clear_idx, rf_write_value=0.
//   - clear_idx increments each cycle. Fill and wb requests are ignored and fill_ready=0.
//   - When clear_idx==NUM_STRANDS*32-1 has been written, the next state is RUN and sc_init_busy drops.
//   - Total: NUM_STRANDS*32 write cycles. sc_init_busy is 1 from reset through the last clear write.
// - RUN state, fixed priority:
//   - If wb_enable_scalar_writeback, the wb request wins.
//   - Otherwise, if fill_valid, the fill request wins and fill_ready=1 (combinational on the inputs).
//   - If neither is requesting, rf_write_enable=0 in the next cycle.
// - Starvation:
//   - starve_cnt increments on each cycle with fill_valid && wb_enable; it clears when the fill is accepted.
//   - sc_stall_request=1 (registered) once starve_cnt reaches STARVE_LIMIT. It clears the cycle after the fill is accepted.
//   - The pipeline answers the stall with a bubble (wb_enable=0).
//   - The counter saturates at STARVE_LIMIT and never wraps.
// - Forwarding:
//   - Sampled in cycle N: fwdX = rf_write_enable && (ds_scalar_selX == rf_write_reg). The current rf_write_value is captured.
//   - In cycle N+1: sc_scalar_valueX = fwdX ? captured_value : rf_scalar_valueX.
//   - Both ports are independent. Both may forward the same write.
//   - Forwarding also applies during CLEAR and returns 0.
// - Reset asserted mid-CLEAR or mid-RUN:
//   - The sequence restarts from clear_idx=0 on the next edge.
//   - No rf_write_enable in the reset cycle. A pending fill is dropped (fill_ready=0).
// - Protocol errors, caught by simulation-only assertions:
//   - wb_enable while sc_init_busy.
//   - fill_reg or fill_value changing while fill_valid && !fill_ready.
// STRUCTURE
// - Package entries (shared, in defines/package): scalar_rf_state_t enum {CLEAR, RUN} and RF_TOTAL_REGS = NUM_STRANDS*32.
//   The type scalar_wb_req_t {logic en; logic[REG_IDX_WIDTH-1:0] idx; logic[31:0] val} is also shared.
// - One natural sub-module: scalar_rf_bypass, instantiated twice (one per read port).
//   It contains the collision compare, the captured-value register, the forward flag and the output mux.
// - The clear FSM, arbiter and starvation counter stay in the top.
// TESTING
// - Reset, then idle: 128 writes of 0 (idx 0..127 for 4 strands).
//   sc_init_busy drops the cycle after the idx=127 write. All registers read 0 afterwards.
// - wb (reg 5, 0xDEADBEEF) and fill (reg 9, 0x1234) both request in one cycle:
//   reg 5 is written at N+1 and fill_ready=0. Reg 9 is written at N+2 with fill_ready=1 in N+1.
// - wb busy every cycle with fill_valid held:
//   sc_stall_request rises after 8 blocked cycles. A wb bubble lets the fill commit. The stall drops one cycle later.
// - rf_write reg 3=0xA5A5A5A5 while ds_scalar_sel1=3 and sel2=4:
//   next cycle sc_scalar_value1=0xA5A5A5A5 (never X), and sc_scalar_value2 is the stored reg 4.
// - Reset pulsed at clear_idx=40: no write in the reset cycle, the clear restarts at idx 0, and all 128 are re-cleared.
// - Random wb/fill/read mix against a reference model: no X on sc_scalar_value*, no lost or duplicated fill.

Source files
------------

// File: rtl/scalar_rf_write_controller_pkg.sv
// Shared types and sizing for the scalar register file write controller.
package scalar_rf_write_controller_pkg;

  localparam int unsigned SC_NUM_STRANDS   = 4;
  localparam int unsigned SC_REG_IDX_WIDTH = $clog2(SC_NUM_STRANDS * 32);
  localparam int unsigned RF_TOTAL_REGS    = SC_NUM_STRANDS * 32;

  typedef enum logic {
    CLEAR,
    RUN
  } scalar_rf_state_t;

  typedef struct packed {
    logic                        en;
    logic [SC_REG_IDX_WIDTH-1:0] idx;
    logic [31:0]                 val;
  } scalar_wb_req_t;

endpackage

// File: rtl/scalar_rf_bypass.sv
// One read port's collision bypass: flags a read that hits the in-flight write and
// substitutes the captured write data for the register file's undefined result.
module scalar_rf_bypass #(
  parameter int unsigned REG_IDX_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [REG_IDX_WIDTH-1:0] wr_reg,
  input  logic [31:0]              wr_value,
  input  logic [REG_IDX_WIDTH-1:0] sel,
  input  logic [31:0]              rf_value,
  output logic [31:0]              value
);

  logic        fwd_q;
  logic [31:0] captured_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_q <= 1'b0;
    end else begin
      fwd_q <= wr_en && (sel == wr_reg);
    end
  end

  // Data path needs no reset; it is only observed when fwd_q is set.
  always_ff @(posedge clk) begin
    captured_q <= wr_value;
  end

  always_comb begin
    value = fwd_q ? captured_q : rf_value;
  end

endmodule

// File: rtl/scalar_rf_write_controller.sv
// Owns the scalar register file write port: post-reset clear, wb/fill arbitration with
// starvation stall, and read-after-write forwarding. REG_IDX_WIDTH must match the package.
module scalar_rf_write_controller
  import scalar_rf_write_controller_pkg::*;
#(
  parameter int unsigned NUM_STRANDS   = SC_NUM_STRANDS,
  parameter int unsigned REG_IDX_WIDTH = SC_REG_IDX_WIDTH,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_enable_scalar_writeback,
  input  logic [REG_IDX_WIDTH-1:0] wb_writeback_reg,
  input  logic [31:0]              wb_writeback_value,
  input  logic                     fill_valid,
  input  logic [REG_IDX_WIDTH-1:0] fill_reg,
  input  logic [31:0]              fill_value,
  output logic                     fill_ready,
  output logic                     sc_stall_request,
  output logic                     sc_init_busy,
  output logic                     rf_write_enable,
  output logic [REG_IDX_WIDTH-1:0] rf_write_reg,
  output logic [31:0]              rf_write_value,
  input  logic [REG_IDX_WIDTH-1:0] ds_scalar_sel1,
  input  logic [REG_IDX_WIDTH-1:0] ds_scalar_sel2,
  input  logic [31:0]              rf_scalar_value1,
  input  logic [31:0]              rf_scalar_value2,
  output logic [31:0]              sc_scalar_value1,
  output logic [31:0]              sc_scalar_value2
);

  localparam int unsigned TotalRegs = NUM_STRANDS * 32;
  localparam int unsigned CntWidth  = $clog2(STARVE_LIMIT + 1);
  localparam logic [REG_IDX_WIDTH-1:0] LastIdx = REG_IDX_WIDTH'(TotalRegs - 1);
  localparam logic [CntWidth-1:0]      CntMax  = CntWidth'(STARVE_LIMIT);

  scalar_rf_state_t         state_q, state_d;
  logic [REG_IDX_WIDTH-1:0] clear_idx_q, clear_idx_d;
  logic                     busy_q;
  scalar_wb_req_t           req_q, req_d;
  logic [CntWidth-1:0]      starve_cnt_q, starve_cnt_d;
  logic                     stall_q;
  logic                     fill_grant;

  always_comb begin
    state_d      = state_q;
    clear_idx_d  = clear_idx_q;
    req_d        = '0;
    fill_grant   = 1'b0;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      CLEAR: begin
        req_d.en    = 1'b1;
        req_d.idx   = clear_idx_q;
        req_d.val   = 32'h0;
        clear_idx_d = clear_idx_q + REG_IDX_WIDTH'(1);
        if (clear_idx_q == LastIdx) begin
          state_d     = RUN;
          clear_idx_d = '0;
        end
      end
      RUN: begin
        if (wb_enable_scalar_writeback) begin
          req_d.en  = 1'b1;
          req_d.idx = wb_writeback_reg;
          req_d.val = wb_writeback_value;
          if (fill_valid && (starve_cnt_q != CntMax)) begin
            starve_cnt_d = starve_cnt_q + CntWidth'(1);
          end
        end else if (fill_valid) begin
          req_d.en     = 1'b1;
          req_d.idx    = fill_reg;
          req_d.val    = fill_value;
          fill_grant   = 1'b1;
          starve_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clear_idx_q  <= '0;
      busy_q       <= 1'b1;
      req_q        <= '0;
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_idx_q  <= clear_idx_d;
      // Lags state by one so busy covers the cycle the last clear write is on the port.
      busy_q       <= (state_q == CLEAR);
      req_q        <= req_d;
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= (starve_cnt_d == CntMax);
    end
  end

  always_comb begin
    fill_ready       = fill_grant && !reset;
    sc_stall_request = stall_q;
    sc_init_busy     = busy_q;
    rf_write_enable  = req_q.en && !reset;
    rf_write_reg     = req_q.idx;
    rf_write_value   = req_q.val;
  end

  scalar_rf_bypass #(
    .REG_IDX_WIDTH(REG_IDX_WIDTH)
  ) u_bypass1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rf_write_enable),
    .wr_reg  (rf_write_reg),
    .wr_value(rf_write_value),
    .sel     (ds_scalar_sel1),
    .rf_value(rf_scalar_value1),
    .value   (sc_scalar_value1)
  );

  scalar_rf_bypass #(
    .REG_IDX_WIDTH(REG_IDX_WIDTH)
  ) u_bypass2 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rf_write_enable),
    .wr_reg  (rf_write_reg),
    .wr_value(rf_write_value),
    .sel     (ds_scalar_sel2),
    .rf_value(rf_scalar_value2),
    .value   (sc_scalar_value2)
  );

`ifndef SYNTHESIS
  wb_while_busy_a: assert property (@(posedge clk) disable iff (reset)
    !(wb_enable_scalar_writeback && sc_init_busy));
  fill_stable_a: assert property (@(posedge clk) disable iff (reset)
    (fill_valid && !fill_ready) |=>
      (!fill_valid || ($stable(fill_reg) && $stable(fill_value))));
`endif

endmodule

// File: tb/tb_scalar_rf_write_controller.sv
// Bench for scalar_rf_write_controller: directed scenarios plus a randomized mix checked
// against an architectural register/arbitration model; the register file is modelled here.
module tb_scalar_rf_write_controller;

  localparam int unsigned NREGS  = 128;
  localparam int unsigned STARVE = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_enable_scalar_writeback;
  logic [6:0]  wb_writeback_reg;
  logic [31:0] wb_writeback_value;
  logic        fill_valid;
  logic [6:0]  fill_reg;
  logic [31:0] fill_value;
  logic        fill_ready;
  logic        sc_stall_request;
  logic        sc_init_busy;
  logic        rf_write_enable;
  logic [6:0]  rf_write_reg;
  logic [31:0] rf_write_value;
  logic [6:0]  ds_scalar_sel1;
  logic [6:0]  ds_scalar_sel2;
  logic [31:0] rf_scalar_value1;
  logic [31:0] rf_scalar_value2;
  logic [31:0] sc_scalar_value1;
  logic [31:0] sc_scalar_value2;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_regs [NREGS];
  logic [31:0] rf_mem     [NREGS];

  always #5 clk = ~clk;

  scalar_rf_write_controller #(
    .NUM_STRANDS  (4),
    .REG_IDX_WIDTH(7),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .wb_enable_scalar_writeback(wb_enable_scalar_writeback),
    .wb_writeback_reg          (wb_writeback_reg),
    .wb_writeback_value        (wb_writeback_value),
    .fill_valid                (fill_valid),
    .fill_reg                  (fill_reg),
    .fill_value                (fill_value),
    .fill_ready                (fill_ready),
    .sc_stall_request          (sc_stall_request),
    .sc_init_busy              (sc_init_busy),
    .rf_write_enable           (rf_write_enable),
    .rf_write_reg              (rf_write_reg),
    .rf_write_value            (rf_write_value),
    .ds_scalar_sel1            (ds_scalar_sel1),
    .ds_scalar_sel2            (ds_scalar_sel2),
    .rf_scalar_value1          (rf_scalar_value1),
    .rf_scalar_value2          (rf_scalar_value2),
    .sc_scalar_value1          (sc_scalar_value1),
    .sc_scalar_value2          (sc_scalar_value2)
  );

  // Register file without reset: 1-cycle read latency, X on a same-cycle collision.
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_reg] <= rf_write_value;
    rf_scalar_value1 <= (rf_write_enable && rf_write_reg == ds_scalar_sel1) ? 32'hx
                                                                           : rf_mem[ds_scalar_sel1];
    rf_scalar_value2 <= (rf_write_enable && rf_write_reg == ds_scalar_sel2) ? 32'hx
                                                                           : rf_mem[ds_scalar_sel2];
  end

  task automatic test_reset();
    reset = 1'b1;
    fill_valid = 1'b1;
    fill_reg = 7'd9;
    fill_value = 32'h1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (sc_init_busy !== 1'b1 || rf_write_enable !== 1'b0 || fill_ready !== 1'b0 ||
        sc_stall_request !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: busy=%b we=%b ready=%b stall=%b required 1 0 0 0",
               sc_init_busy, rf_write_enable, fill_ready, sc_stall_request);
    end
    fill_valid = 1'b0;
    reset = 1'b0;
  endtask

  // Expects the DUT to be one negedge after reset release; checks all clear writes.
  task automatic run_clear(input bit check_fwd);
    for (int k = 0; k < NREGS; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (rf_write_enable !== 1'b1 || rf_write_reg !== 7'(k) || rf_write_value !== 32'h0 ||
          sc_init_busy !== 1'b1) begin
        bad++;
        $display("FAIL clear_write[%0d]: we=%b reg=%0d val=%h busy=%b required 1 %0d 0 1",
                 k, rf_write_enable, rf_write_reg, rf_write_value, sc_init_busy, k);
      end
      if (check_fwd && k == 6) begin
        total++;
        if (sc_scalar_value1 !== 32'h0) begin
          bad++;
          $display("FAIL clear_forward: sc1=%h required 0", sc_scalar_value1);
        end
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (sc_init_busy !== 1'b0 || rf_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL clear_done: busy=%b we=%b required 0 0", sc_init_busy, rf_write_enable);
    end
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
  endtask

  task automatic test_clear_readback();
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      ds_scalar_sel1 = 7'(i);
      ds_scalar_sel2 = 7'(NREGS - 1 - i);
      @(posedge clk);
      #1;
      total++;
      if (sc_scalar_value1 !== 32'h0 || sc_scalar_value2 !== 32'h0) begin
        bad++;
        $display("FAIL readback[%0d]: sc1=%h sc2=%h required 0 0",
                 i, sc_scalar_value1, sc_scalar_value2);
      end
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b1;
    wb_writeback_reg = 7'd5;
    wb_writeback_value = 32'hDEADBEEF;
    fill_valid = 1'b1;
    fill_reg = 7'd9;
    fill_value = 32'h1234;
    #1;
    total++;
    if (fill_ready !== 1'b0) begin
      bad++;
      $display("FAIL prio_ready_blocked: ready=%b required 0", fill_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (rf_write_enable !== 1'b1 || rf_write_reg !== 7'd5 || rf_write_value !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL prio_wb_write: we=%b reg=%0d val=%h required 1 5 deadbeef",
               rf_write_enable, rf_write_reg, rf_write_value);
    end
    model_regs[5] = 32'hDEADBEEF;
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b0;
    #1;
    total++;
    if (fill_ready !== 1'b1) begin
      bad++;
      $display("FAIL prio_ready_grant: ready=%b required 1", fill_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if (rf_write_enable !== 1'b1 || rf_write_reg !== 7'd9 || rf_write_value !== 32'h1234) begin
      bad++;
      $display("FAIL prio_fill_write: we=%b reg=%0d val=%h required 1 9 1234",
               rf_write_enable, rf_write_reg, rf_write_value);
    end
    model_regs[9] = 32'h1234;
    @(negedge clk);
    fill_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rf_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL prio_idle: we=%b required 0", rf_write_enable);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] v;
    logic        exp_stall;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      v = $urandom();
      fill_valid = 1'b1;
      fill_reg = 7'd20;
      fill_value = 32'hCAFE0001;
      wb_enable_scalar_writeback = 1'b1;
      wb_writeback_reg = 7'd30;
      wb_writeback_value = v;
      @(posedge clk);
      #1;
      exp_stall = (k >= int'(STARVE));
      total++;
      if (sc_stall_request !== exp_stall || rf_write_reg !== 7'd30 || rf_write_value !== v) begin
        bad++;
        $display("FAIL starve_cycle[%0d]: stall=%b reg=%0d val=%h required %b 30 %h",
                 k, sc_stall_request, rf_write_reg, rf_write_value, exp_stall, v);
      end
      model_regs[30] = v;
    end
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b0;
    #1;
    total++;
    if (fill_ready !== 1'b1 || sc_stall_request !== 1'b1) begin
      bad++;
      $display("FAIL starve_bubble: ready=%b stall=%b required 1 1", fill_ready, sc_stall_request);
    end
    @(posedge clk);
    #1;
    total++;
    if (sc_stall_request !== 1'b0 || rf_write_enable !== 1'b1 || rf_write_reg !== 7'd20 ||
        rf_write_value !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL starve_release: stall=%b we=%b reg=%0d val=%h required 0 1 20 cafe0001",
               sc_stall_request, rf_write_enable, rf_write_reg, rf_write_value);
    end
    model_regs[20] = 32'hCAFE0001;
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [31:0] v;
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b1;
    wb_writeback_reg = 7'd3;
    wb_writeback_value = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b0;
    ds_scalar_sel1 = 7'd3;
    ds_scalar_sel2 = 7'd4;
    @(posedge clk);
    #1;
    total++;
    if (sc_scalar_value1 !== 32'hA5A5A5A5 || sc_scalar_value2 !== model_regs[4]) begin
      bad++;
      $display("FAIL fwd_port1: sc1=%h sc2=%h required a5a5a5a5 %h",
               sc_scalar_value1, sc_scalar_value2, model_regs[4]);
    end
    model_regs[3] = 32'hA5A5A5A5;
    v = $urandom();
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b1;
    wb_writeback_reg = 7'd7;
    wb_writeback_value = v;
    @(posedge clk);
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b0;
    ds_scalar_sel1 = 7'd7;
    ds_scalar_sel2 = 7'd7;
    @(posedge clk);
    #1;
    total++;
    if (sc_scalar_value1 !== v || sc_scalar_value2 !== v) begin
      bad++;
      $display("FAIL fwd_both: sc1=%h sc2=%h required %h %h",
               sc_scalar_value1, sc_scalar_value2, v, v);
    end
    model_regs[7] = v;
  endtask

  task automatic test_random();
    logic        pend = 1'b0;
    logic [6:0]  f_reg = '0;
    logic [31:0] f_val = '0;
    logic        nx_en = 1'b0;
    logic [6:0]  nx_reg = '0;
    logic [31:0] nx_val = '0;
    logic        do_wb, exp_ready, exp_stall;
    logic [6:0]  s1, s2;
    logic [31:0] e1, e2;
    int          blocked = 0;
    int          acc = 0;
    int          dut_acc = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (nx_en) model_regs[nx_reg] = nx_val;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        f_reg = 7'($urandom_range(0, NREGS - 1));
        f_val = $urandom();
      end
      do_wb = (blocked < int'(STARVE)) && ($urandom_range(0, 9) < 7);
      wb_enable_scalar_writeback = do_wb;
      wb_writeback_reg = 7'($urandom_range(0, NREGS - 1));
      wb_writeback_value = $urandom();
      fill_valid = pend;
      fill_reg = f_reg;
      fill_value = f_val;
      s1 = 7'($urandom_range(0, NREGS - 1));
      s2 = ($urandom_range(0, 3) == 0) ? s1 : 7'($urandom_range(0, NREGS - 1));
      ds_scalar_sel1 = s1;
      ds_scalar_sel2 = s2;
      e1 = model_regs[s1];
      e2 = model_regs[s2];
      exp_ready = pend && !do_wb;
      #1;
      total++;
      if (fill_ready !== exp_ready) begin
        bad++;
        $display("FAIL rand_ready[%0d]: ready=%b required %b", c, fill_ready, exp_ready);
      end
      if (fill_ready === 1'b1) dut_acc++;
      nx_en = do_wb || pend;
      nx_reg = do_wb ? wb_writeback_reg : f_reg;
      nx_val = do_wb ? wb_writeback_value : f_val;
      if (pend && do_wb) begin
        if (blocked < int'(STARVE)) blocked++;
      end else if (exp_ready) begin
        blocked = 0;
        acc++;
        pend = 1'b0;
      end
      exp_stall = (blocked >= int'(STARVE));
      @(posedge clk);
      #1;
      total++;
      if (rf_write_enable !== nx_en ||
          (nx_en && (rf_write_reg !== nx_reg || rf_write_value !== nx_val))) begin
        bad++;
        $display("FAIL rand_write[%0d]: we=%b reg=%0d val=%h required %b %0d %h",
                 c, rf_write_enable, rf_write_reg, rf_write_value, nx_en, nx_reg, nx_val);
      end
      total++;
      if (sc_stall_request !== exp_stall) begin
        bad++;
        $display("FAIL rand_stall[%0d]: stall=%b required %b", c, sc_stall_request, exp_stall);
      end
      total++;
      if (sc_scalar_value1 !== e1 || sc_scalar_value2 !== e2) begin
        bad++;
        $display("FAIL rand_read[%0d]: sc1=%h sc2=%h required %h %h",
                 c, sc_scalar_value1, sc_scalar_value2, e1, e2);
      end
    end
    @(negedge clk);
    wb_enable_scalar_writeback = 1'b0;
    fill_valid = 1'b0;
    total++;
    if (dut_acc != acc) begin
      bad++;
      $display("FAIL rand_fill_count: accepted=%0d required %0d", dut_acc, acc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ds_scalar_sel1 = 7'd5;
    for (int k = 0; k < 41; k++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (rf_write_enable !== 1'b1 || rf_write_reg !== 7'd40) begin
      bad++;
      $display("FAIL midclear_at40: we=%b reg=%0d required 1 40", rf_write_enable, rf_write_reg);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (rf_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL midclear_reset_cycle: we=%b required 0", rf_write_enable);
    end
    @(posedge clk);
    #1;
    total++;
    if (rf_write_enable !== 1'b0 || sc_init_busy !== 1'b1) begin
      bad++;
      $display("FAIL midclear_after_edge: we=%b busy=%b required 0 1",
               rf_write_enable, sc_init_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    run_clear(1'b1);
  endtask

  initial begin
    wb_enable_scalar_writeback = 1'b0;
    wb_writeback_reg = '0;
    wb_writeback_value = '0;
    fill_valid = 1'b0;
    fill_reg = '0;
    fill_value = '0;
    ds_scalar_sel1 = '0;
    ds_scalar_sel2 = '0;
    test_reset();
    run_clear(1'b0);
    test_clear_readback();
    test_priority();
    test_starvation();
    test_forwarding();
    test_random();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
